// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared encodings for the ARM-subset decode stage
package id_stage_pkg;
  typedef enum logic [1:0] {
    MODE_ARITH  = 2'b00,
    MODE_MEM    = 2'b01,
    MODE_BRANCH = 2'b10,
    MODE_NONE   = 2'b11
  } mode_e;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond_e'(cond))
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/id_stage_register_file.sv
// register_file: 16x32 registers, sync write, async read with write-through bypass, reset loads index
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rn_addr,
  input  logic [3:0]  rm_addr,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rn_data,
  output logic [31:0] rm_data
);
  logic [31:0] regs [16];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 16; i++) regs[i] <= 32'(i);
    else if (wr_en) regs[wr_addr] <= wr_data;
  assign rn_data = wr_en && wr_addr == rn_addr ? wr_data : regs[rn_addr];
  assign rm_data = wr_en && wr_addr == rm_addr ? wr_data : regs[rm_addr];
endmodule

// File: rtl/id_stage.sv
// id_stage: ARM-subset decode stage; decodes instruction, reads register file, checks condition, latches ID/EXE register
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] PCIn,
  input  logic        flush,
  input  logic [3:0]  statusRegister,
  input  logic        WB_EN,
  input  logic [3:0]  WBDest,
  input  logic [31:0] WBValue,
  input  logic        hazard,
  output logic [3:0]  RnAddress,
  output logic [3:0]  RmAddress,
  output logic        Two_src,
  output logic [3:0]  dest,
  output logic [23:0] branchImm,
  output logic        I,
  output logic [11:0] shiftOperand,
  output logic [31:0] RmValue,
  output logic [31:0] RnValue,
  output logic [31:0] PC,
  output logic        S,
  output logic        B,
  output logic [3:0]  EXE_CMD,
  output logic        MEM_W_EN,
  output logic        MEM_R_EN,
  output logic        WB_EN_OUT
);
  mode_e       mode;
  logic [3:0]  opcode;
  logic        l_bit, is_str, go;
  logic [3:0]  dec_cmd;
  logic        dec_wb, dec_mr, dec_mw, dec_b, dec_s;
  logic [31:0] rn_data, rm_data;
  assign mode      = mode_e'(instruction[27:26]);
  assign opcode    = instruction[24:21];
  assign l_bit     = instruction[20];
  assign is_str    = mode == MODE_MEM && !l_bit;
  assign RnAddress = instruction[19:16];
  assign RmAddress = is_str ? instruction[15:12] : instruction[3:0];
  assign Two_src   = !instruction[25] || is_str;
  assign go        = cond_pass(instruction[31:28], statusRegister) && !hazard;
  always_comb begin
    dec_cmd = CMD_NOP;
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    case (mode)
      MODE_ARITH: begin
        dec_s = l_bit;
        case (opcode)
          OP_MOV:  dec_cmd = CMD_MOV;
          OP_MVN:  dec_cmd = CMD_MVN;
          OP_ADD:  dec_cmd = CMD_ADD;
          OP_ADC:  dec_cmd = CMD_ADC;
          OP_SUB:  dec_cmd = CMD_SUB;
          OP_SBC:  dec_cmd = CMD_SBC;
          OP_AND:  dec_cmd = CMD_AND;
          OP_ORR:  dec_cmd = CMD_ORR;
          OP_EOR:  dec_cmd = CMD_EOR;
          OP_CMP:  dec_cmd = CMD_SUB;
          OP_TST:  dec_cmd = CMD_AND;
          default: dec_cmd = CMD_NOP;
        endcase
        dec_wb = dec_cmd != CMD_NOP && opcode != OP_CMP && opcode != OP_TST;
      end
      MODE_MEM: begin
        dec_cmd = CMD_ADD;
        dec_mr  = l_bit;
        dec_mw  = !l_bit;
        dec_wb  = l_bit;
      end
      MODE_BRANCH: dec_b = 1'b1;
      default: dec_b = 1'b0;
    endcase
  end
  register_file u_rf (
    .clk     (clk),
    .rst     (rst),
    .rn_addr (RnAddress),
    .rm_addr (RmAddress),
    .wr_en   (WB_EN),
    .wr_addr (WBDest),
    .wr_data (WBValue),
    .rn_data (rn_data),
    .rm_data (rm_data)
  );
  always_ff @(posedge clk)
    if (rst || flush) begin
      dest         <= '0;
      branchImm    <= '0;
      I            <= 1'b0;
      shiftOperand <= '0;
      RmValue      <= '0;
      RnValue      <= '0;
      PC           <= '0;
      S            <= 1'b0;
      B            <= 1'b0;
      EXE_CMD      <= '0;
      MEM_W_EN     <= 1'b0;
      MEM_R_EN     <= 1'b0;
      WB_EN_OUT    <= 1'b0;
    end else begin
      dest         <= instruction[15:12];
      branchImm    <= instruction[23:0];
      I            <= instruction[25];
      shiftOperand <= instruction[11:0];
      RmValue      <= rm_data;
      RnValue      <= rn_data;
      PC           <= PCIn;
      S            <= go && dec_s;
      B            <= go && dec_b;
      EXE_CMD      <= go ? dec_cmd : CMD_NOP;
      MEM_W_EN     <= go && dec_mw;
      MEM_R_EN     <= go && dec_mr;
      WB_EN_OUT    <= go && dec_wb;
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized and directed self-checking bench for id_stage against a table-driven reference model
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst, flush, WB_EN, hazard;
  logic [31:0] instruction, PCIn, WBValue;
  logic [3:0]  statusRegister, WBDest;
  logic [3:0]  RnAddress, RmAddress, dest, EXE_CMD;
  logic        Two_src, I, S, B, MEM_W_EN, MEM_R_EN, WB_EN_OUT;
  logic [23:0] branchImm;
  logic [11:0] shiftOperand;
  logic [31:0] RmValue, RnValue, PC;
  int checks = 0, failures = 0;
  logic [31:0] mregs [16];
  logic [3:0]  cmd_tab [16];
  id_stage dut (
    .clk(clk), .rst(rst), .instruction(instruction), .PCIn(PCIn), .flush(flush),
    .statusRegister(statusRegister), .WB_EN(WB_EN), .WBDest(WBDest), .WBValue(WBValue),
    .hazard(hazard), .RnAddress(RnAddress), .RmAddress(RmAddress), .Two_src(Two_src),
    .dest(dest), .branchImm(branchImm), .I(I), .shiftOperand(shiftOperand),
    .RmValue(RmValue), .RnValue(RnValue), .PC(PC), .S(S), .B(B), .EXE_CMD(EXE_CMD),
    .MEM_W_EN(MEM_W_EN), .MEM_R_EN(MEM_R_EN), .WB_EN_OUT(WB_EN_OUT)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic pass_of(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic [15:0] t;
    {n, z, c, v} = f;
    t = {1'b0, 1'b1, z | (n ^ v), !z & !(n ^ v), n ^ v, !(n ^ v), !c | z, c & !z,
         !v, v, !n, n, !c, c, !z, z};
    return t[cond];
  endfunction
  function automatic logic [31:0] rd(input logic [3:0] a);
    return (WB_EN && WBDest == a) ? WBValue : mregs[a];
  endfunction
  task automatic step();
    logic [1:0]  md;
    logic [3:0]  op, ra, cmd;
    logic        l, st, ok, wb, mr, mw, bb, ss, clr;
    logic [31:0] rn_v, rm_v;
    md = instruction[27:26];
    op = instruction[24:21];
    l  = instruction[20];
    st = md == 2'd1 && !l;
    ra = st ? instruction[15:12] : instruction[3:0];
    #1;
    chk("rn_addr", 32'(RnAddress), 32'(instruction[19:16]));
    chk("rm_addr", 32'(RmAddress), 32'(ra));
    chk("two_src", 32'(Two_src), 32'(!instruction[25] || st));
    ok   = pass_of(instruction[31:28], statusRegister) && !hazard;
    cmd  = md == 2'd0 ? cmd_tab[op] : md == 2'd1 ? 4'd2 : 4'd0;
    wb   = (md == 2'd0 && cmd_tab[op] != 0 && op != 4'hA && op != 4'h8) || (md == 2'd1 && l);
    mr   = md == 2'd1 && l;
    mw   = st;
    bb   = md == 2'd2;
    ss   = md == 2'd0 && l;
    rn_v = rd(instruction[19:16]);
    rm_v = rd(ra);
    clr  = rst || flush;
    @(posedge clk);
    #1;
    chk("dest",      32'(dest),         clr ? 0 : 32'(instruction[15:12]));
    chk("branchImm", 32'(branchImm),    clr ? 0 : 32'(instruction[23:0]));
    chk("I",         32'(I),            clr ? 0 : 32'(instruction[25]));
    chk("shiftOp",   32'(shiftOperand), clr ? 0 : 32'(instruction[11:0]));
    chk("RnValue",   RnValue,           clr ? 0 : rn_v);
    chk("RmValue",   RmValue,           clr ? 0 : rm_v);
    chk("PC",        PC,                clr ? 0 : PCIn);
    chk("S",         32'(S),            32'(!clr && ok && ss));
    chk("B",         32'(B),            32'(!clr && ok && bb));
    chk("EXE_CMD",   32'(EXE_CMD),      (!clr && ok) ? 32'(cmd) : 0);
    chk("MEM_W_EN",  32'(MEM_W_EN),     32'(!clr && ok && mw));
    chk("MEM_R_EN",  32'(MEM_R_EN),     32'(!clr && ok && mr));
    chk("WB_EN_OUT", 32'(WB_EN_OUT),    32'(!clr && ok && wb));
    if (rst) for (int i = 0; i < 16; i++) mregs[i] = 32'(i);
    else if (WB_EN) mregs[WBDest] = WBValue;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) cmd_tab[i] = 4'd0;
    cmd_tab[13] = 4'd1; cmd_tab[15] = 4'd9; cmd_tab[4] = 4'd2; cmd_tab[5] = 4'd3;
    cmd_tab[2]  = 4'd4; cmd_tab[6]  = 4'd5; cmd_tab[0] = 4'd6; cmd_tab[12] = 4'd7;
    cmd_tab[1]  = 4'd8; cmd_tab[10] = 4'd4; cmd_tab[8] = 4'd6;
    for (int i = 0; i < 16; i++) mregs[i] = 32'hdead_0000;
    rst = 1'b1; flush = 1'b0; hazard = 1'b0; instruction = '0; PCIn = 32'h4;
    statusRegister = 4'b0000; WB_EN = 1'b1; WBDest = 4'd2; WBValue = 32'd5;
    step();
    chk("rst_wb", 32'(WB_EN_OUT), 0);
    chk("rst_pc", PC, 0);
    rst = 1'b0;
    step();
    chk("bubble_wb", 32'(WB_EN_OUT), 0);
    chk("bubble_cmd", 32'(EXE_CMD), 0);
    WB_EN = 1'b0; instruction = 32'hE3A00014; PCIn = 32'h8;
    #1 chk("mov_two_src", 32'(Two_src), 0);
    step();
    chk("mov_cmd", 32'(EXE_CMD), 1);
    chk("mov_wb", 32'(WB_EN_OUT), 1);
    chk("mov_i", 32'(I), 1);
    chk("mov_dest", 32'(dest), 0);
    chk("mov_shift", 32'(shiftOperand), 32'h014);
    instruction = 32'hE0923002;
    #1 chk("adds_two_src", 32'(Two_src), 1);
    step();
    chk("adds_cmd", 32'(EXE_CMD), 2);
    chk("adds_s", 32'(S), 1);
    chk("adds_rn", RnValue, 5);
    chk("adds_rm", RmValue, 5);
    chk("adds_dest", 32'(dest), 3);
    instruction = 32'hE1190008;
    step();
    chk("tst_cmd", 32'(EXE_CMD), 6);
    chk("tst_s", 32'(S), 1);
    chk("tst_wb", 32'(WB_EN_OUT), 0);
    chk("tst_rn", RnValue, 9);
    instruction = 32'hE4001000;
    #1 chk("str_rm_addr", 32'(RmAddress), 1);
    chk("str_two_src", 32'(Two_src), 1);
    step();
    chk("str_mw", 32'(MEM_W_EN), 1);
    chk("str_cmd", 32'(EXE_CMD), 2);
    instruction = 32'hE410B000;
    step();
    chk("ldr_mr", 32'(MEM_R_EN), 1);
    chk("ldr_wb", 32'(WB_EN_OUT), 1);
    chk("ldr_dest", 32'(dest), 11);
    instruction = 32'hE0823002; hazard = 1'b1;
    step();
    chk("haz_cmd", 32'(EXE_CMD), 0);
    chk("haz_wb", 32'(WB_EN_OUT), 0);
    chk("haz_rn", RnValue, 5);
    flush = 1'b1;
    step();
    chk("flush_dest", 32'(dest), 0);
    chk("flush_rn", RnValue, 0);
    hazard = 1'b0; flush = 1'b0;
    WB_EN = 1'b1; WBDest = 4'd7; WBValue = 32'h1234_5678; instruction = 32'hE0870007;
    step();
    chk("bypass_rn", RnValue, 32'h1234_5678);
    chk("bypass_rm", RmValue, 32'h1234_5678);
    for (int n = 0; n < 600; n++) begin
      instruction = $urandom;
      if ($urandom_range(1, 0) == 1) instruction[31:28] = 4'hE;
      if ($urandom_range(3, 0) == 0) instruction[27:26] = 2'b00;
      PCIn = $urandom;
      statusRegister = 4'($urandom);
      WB_EN = 1'($urandom);
      WBDest = 4'($urandom);
      WBValue = $urandom;
      hazard = $urandom_range(9, 0) == 0;
      flush = $urandom_range(19, 0) == 0;
      rst = $urandom_range(49, 0) == 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage ARM-subset pipeline, between the IF/ID register and the EXE stage. Decodes a 32-bit ARM instruction into control signals, reads two operands from an internal 16×32 register file (written by the WB stage), evaluates the condition field against the status flags, and latches everything into an internal ID/EXE pipeline register. Hazard and condition-fail cases insert a bubble; flush clears the pipeline register.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instruction  in  32  instruction from IF/ID
- PCIn  in  32  PC+4 from IF/ID
- flush  in  1  synchronous clear of ID/EXE register (taken branch)
- statusRegister  in  4  {N,Z,C,V} = bits [3:0]
- WB_EN  in  1  register-file write enable from WB
- WBDest  in  4  write address
- WBValue  in  32  write data
- hazard  in  1  hazard unit request to insert bubble
- RnAddress  out  4  instruction[19:16], combinational (to hazard unit)
- RmAddress  out  4  combinational: instruction[15:12] for STR, else instruction[3:0]
- Two_src  out  1  combinational: ~instruction[25] | STR
- dest  out  4  registered Rd = instruction[15:12]
- branchImm  out  24  registered instruction[23:0]
- I  out  1  registered instruction[25]
- shiftOperand  out  12  registered instruction[11:0]
- RmValue, RnValue  out  32 each  registered register-file read data
- PC  out  32  registered PCIn
- S  out  1  registered update-flags bit
- B  out  1  registered branch
- EXE_CMD  out  4  registered ALU command
- MEM_W_EN, MEM_R_EN  out  1 each  registered memory enables
- WB_EN_OUT  out  1  registered write-back enable

## Operation
- Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S/L[20], Rn[19:16], Rd[15:12], Rm[3:0].
- EXE_CMD for mode 00: MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110; other opcodes→0000 with WB_EN 0. Mode 01 (LDR/STR)→0010. Mode 10→0000.
- WB_EN: mode 00 except CMP/TST; LDR. MEM_R_EN: mode 01 & L=1. MEM_W_EN: mode 01 & L=0. B: mode 10. S: instruction[20] only in mode 00, else 0. Mode 11: all controls 0.
- Condition (N,Z,C,V): EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 → 0.
- Bubble: if condition false or hazard=1, WB_EN, MEM_R_EN, MEM_W_EN, S, B, EXE_CMD latched as 0; data fields latched normally.
- Register file: 16×32, combinational read of Rn and RmAddress; write WBValue to WBDest on rising edge when WB_EN. Read bypass: if WB_EN and WBDest equals read address, read returns WBValue. Reset loads register i with value i.

## Timing
- Decode/read combinational; registered outputs valid one cycle after instruction presented.
- Priority per edge: rst > flush > load. rst or flush: all registered outputs 0.
- Register-file reset and WB write coincident: reset wins.
- Simultaneous WB write and read same register in same cycle: new value latched (bypass).

## Structure
- Shared package: mode encodings, opcode constants, EXE_CMD constants, condition codes.
- Sub-module register_file (16×32, sync write, async read with bypass); decode and condition check inline.

## Test plan
- Reset, instruction=0 (cond EQ, Z=0) → all registered outputs 0 after reset; next cycle bubble (WB_EN_OUT=0, EXE_CMD=0); R2 holds 5 from constant WB write.
- 0xE3A00014 (MOV R0,#20) → EXE_CMD 0001, WB_EN_OUT 1, I 1, dest 0, shiftOperand 0x014, Two_src 0.
- 0xE0923002 (ADDS R3,R2,R2) with R2=5 → EXE_CMD 0010, S 1, RnValue 5, RmValue 5, dest 3, Two_src 1.
- 0xE1190008 (TST R9,R8) → EXE_CMD 0110, S 1, WB_EN_OUT 0, RnValue 9.
- 0xE4001000 (STR R1) → MEM_W_EN 1, RmAddress 1, Two_src 1, EXE_CMD 0010; 0xE410B000 (LDR R11) → MEM_R_EN 1, WB_EN_OUT 1, dest 11.
- ADD with hazard=1 → controls 0; same with flush=1 → all registered outputs 0.
